// File: rtl/ssdma_regs_pkg.sv
// Shared register map for the SSDMA host register file: byte offsets and CCR bit positions.
// Also imported by the controller bench.
package ssdma_regs_pkg;

    localparam logic [31:0] OFS_CCR    = 32'h00;
    localparam logic [31:0] OFS_STAT   = 32'h04;
    localparam logic [31:0] OFS_NDAR   = 32'h08;
    localparam logic [31:0] OFS_DAR    = 32'h0C;
    localparam logic [31:0] OFS_CHAINS = 32'h10;
    localparam logic [31:0] OFS_IRQS   = 32'h14;

    localparam int CCR_ENABLE  = 0;
    localparam int CCR_APPEND  = 1;
    localparam int CCR_INT_CLR = 2;
    localparam int CCR_INT_EN  = 8;

endpackage

// File: rtl/ssdma_regs_if.sv
// Wishbone classic slave bus between the host and the SSDMA register file.
interface ssdma_regs_if #(
    parameter int ADR_W = 5
);
    logic             cyc;
    logic             stb;
    logic             we;
    logic [3:0]       sel;
    logic [ADR_W-1:0] adr;
    logic [31:0]      dat_w;
    logic [31:0]      dat_r;
    logic             ack;
    logic             err;

    modport master (output cyc, stb, we, sel, adr, dat_w, input dat_r, ack, err);
    modport slave  (input cyc, stb, we, sel, adr, dat_w, output dat_r, ack, err);
endinterface

// File: rtl/ssdma_regs.sv
// Host-facing Wishbone register file for the SSDMA engine (CCR, STAT, NDAR, DAR).
// Define SSDMA_REGS_STATS_EN to add the CHAINS/IRQS event counters at 0x10/0x14.
module ssdma_regs
    import ssdma_regs_pkg::*;
#(
    parameter logic RESET_ENABLE = 1'b0,
    parameter int   ADR_W        = 5
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_n_i,
    ssdma_regs_if.slave       wbs,
    output logic              enable,
    output logic              append,
    input  logic              append_clear,
    output logic [28:0]       ndar,
    output logic              ndar_dirty,
    input  logic              ndar_dirty_clear,
    output logic              wb_int_clear,
    input  logic              wb_int_i,
    input  logic [31:0]       dar_i,
    input  logic [7:0]        csr_i,
    input  logic              busy_i,
    input  logic [7:0]        ctrl_state_i,
    output logic              irq_o
);

    logic [ADR_W-1:0] adr;
    logic [31:0]      ofs;
    logic             int_en;
    logic             req;
    logic             wr_commit;
    logic             mapped;
    logic [31:0]      rdata;
    logic [28:0]      ndar_next;
    logic             wr_ccr;
    logic             wr_ndar;

`ifdef SSDMA_REGS_STATS_EN
    logic [31:0]      chains;
    logic [31:0]      irqs;
    logic             wb_int_d;
`endif

    assign adr = wbs.adr;
    assign ofs = {{(32-ADR_W){1'b0}}, adr[ADR_W-1:2], 2'b00};

    // The classic master holds its request through the ack cycle, so the live bus carries the write.
    assign req       = wbs.cyc & wbs.stb & ~wbs.ack & ~wbs.err;
    assign wr_commit = wbs.ack & wbs.cyc & wbs.stb & wbs.we;
    assign wr_ccr    = wr_commit && (ofs == OFS_CCR);
    assign wr_ndar   = wr_commit && (ofs == OFS_NDAR);

    assign irq_o = wb_int_i & int_en;

    always_comb begin
        rdata  = '0;
        mapped = 1'b1;
        case (ofs)
            OFS_CCR: begin
                rdata[CCR_INT_EN] = int_en;
                rdata[CCR_APPEND] = append;
                rdata[CCR_ENABLE] = enable;
            end
            OFS_STAT: rdata = {8'h00, ctrl_state_i, 6'b0, busy_i, wb_int_i, csr_i};
            OFS_NDAR: rdata = {ndar, 3'b000};
            OFS_DAR:  rdata = dar_i;
`ifdef SSDMA_REGS_STATS_EN
            OFS_CHAINS: rdata = chains;
            OFS_IRQS:   rdata = irqs;
`endif
            default: mapped = 1'b0;
        endcase
    end

    // NDAR holds address bits [31:3]; byte lane 0 only contributes bits [7:3].
    always_comb begin
        ndar_next = ndar;
        if (wbs.sel[0]) ndar_next[4:0]   = wbs.dat_w[7:3];
        if (wbs.sel[1]) ndar_next[12:5]  = wbs.dat_w[15:8];
        if (wbs.sel[2]) ndar_next[20:13] = wbs.dat_w[23:16];
        if (wbs.sel[3]) ndar_next[28:21] = wbs.dat_w[31:24];
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            wbs.ack   <= 1'b0;
            wbs.err   <= 1'b0;
            wbs.dat_r <= '0;
        end else begin
            wbs.ack   <= req & mapped;
            wbs.err   <= req & ~mapped;
            wbs.dat_r <= (req && mapped && !wbs.we) ? rdata : '0;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            enable       <= RESET_ENABLE;
            append       <= 1'b0;
            int_en       <= 1'b0;
            wb_int_clear <= 1'b0;
            ndar         <= '0;
            ndar_dirty   <= 1'b0;
        end else begin
            wb_int_clear <= wr_ccr & wbs.sel[0] & wbs.dat_w[CCR_INT_CLR];
            if (wr_ccr && wbs.sel[0])
                enable <= wbs.dat_w[CCR_ENABLE];
            if (wr_ccr && wbs.sel[1])
                int_en <= wbs.dat_w[CCR_INT_EN];
            if (wr_ccr && wbs.sel[0] && wbs.dat_w[CCR_APPEND])
                append <= 1'b1;
            else if (append_clear)
                append <= 1'b0;
            if (wr_ndar)
                ndar <= ndar_next;
            if (wr_ndar && (wbs.sel != 4'b0000))
                ndar_dirty <= 1'b1;
            else if (ndar_dirty_clear)
                ndar_dirty <= 1'b0;
        end
    end

`ifdef SSDMA_REGS_STATS_EN
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            chains   <= '0;
            irqs     <= '0;
            wb_int_d <= 1'b0;
        end else begin
            wb_int_d <= wb_int_i;
            if (wr_commit && (ofs == OFS_CHAINS))
                chains <= '0;
            else if (ndar_dirty_clear | append_clear)
                chains <= chains + 32'd1;
            if (wr_commit && (ofs == OFS_IRQS))
                irqs <= '0;
            else if (wb_int_i & ~wb_int_d)
                irqs <= irqs + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ssdma_regs.sv
// Scoreboard bench for ssdma_regs: bus accesses push expected responses, a monitor pops on ack/err.
module tb_ssdma_regs;
    import ssdma_regs_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        append_clear = 1'b0;
    logic        ndar_dirty_clear = 1'b0;
    logic        wb_int_i = 1'b0;
    logic [31:0] dar_i = '0;
    logic [7:0]  csr_i = '0;
    logic        busy_i = 1'b0;
    logic [7:0]  ctrl_state_i = '0;
    logic        enable, append, ndar_dirty, wb_int_clear, irq_o;
    logic [28:0] ndar;

    always #5 clk = ~clk;

    ssdma_regs_if #(.ADR_W(5)) bus ();

    ssdma_regs #(.RESET_ENABLE(1'b0), .ADR_W(5)) dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n), .wbs(bus),
        .enable(enable), .append(append), .append_clear(append_clear),
        .ndar(ndar), .ndar_dirty(ndar_dirty), .ndar_dirty_clear(ndar_dirty_clear),
        .wb_int_clear(wb_int_clear), .wb_int_i(wb_int_i), .dar_i(dar_i),
        .csr_i(csr_i), .busy_i(busy_i), .ctrl_state_i(ctrl_state_i), .irq_o(irq_o)
    );

    typedef struct packed {
        logic        exp_err;
        logic        chk_dat;
        logic [31:0] dat;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: every ack/err is matched against the oldest expected response.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.ack || bus.err) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_resp: got ack=%b err=%b want none", bus.ack, bus.err);
                end else begin
                    e = sb.pop_front();
                    if ({bus.ack, bus.err} !== {~e.exp_err, e.exp_err} ||
                        (e.chk_dat && bus.dat_r !== e.dat)) begin
                        n_bad++;
                        $display("FAIL bus_resp: got ack=%b err=%b dat=%h want ack=%b err=%b dat=%h",
                                 bus.ack, bus.err, bus.dat_r, ~e.exp_err, e.exp_err, e.dat);
                    end
                end
            end
        end
    end

    task automatic access(input logic we, input logic [4:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input logic exp_err, input logic [31:0] exp_dat,
                          input logic hold_clr = 1'b0);
        exp_t e;
        int   k;
        e.exp_err = exp_err;
        e.chk_dat = ~we | exp_err;
        e.dat     = exp_dat;
        sb.push_back(e);
        @(posedge clk); #1;
        bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = we;
        bus.adr = adr; bus.dat_w = dat; bus.sel = sel;
        ndar_dirty_clear = hold_clr;
        k = 0;
        do begin
            @(posedge clk); #1;
            k++;
        end while (!(bus.ack || bus.err) && k < 8);
        if (!(bus.ack || bus.err)) begin
            n_vec++;
            n_bad++;
            $display("FAIL bus_timeout: got no ack/err want response at adr %h", adr);
        end
        @(posedge clk); #1;
        bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
        ndar_dirty_clear = 1'b0;
    endtask

    task automatic wr(input logic [4:0] adr, input logic [31:0] dat, input logic [3:0] sel = 4'hF,
                      input logic hold_clr = 1'b0);
        access(1'b1, adr, dat, sel, 1'b0, 32'h0, hold_clr);
    endtask

    task automatic rd(input logic [4:0] adr, input logic [31:0] exp_dat);
        access(1'b0, adr, 32'h0, 4'hF, 1'b0, exp_dat);
    endtask

    task automatic pulse_append;
        @(posedge clk); #1 append_clear = 1'b1;
        @(posedge clk); #1 append_clear = 1'b0;
    endtask

    task automatic pulse_dirty;
        @(posedge clk); #1 ndar_dirty_clear = 1'b1;
        @(posedge clk); #1 ndar_dirty_clear = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_ack"}, 32'(bus.ack), 32'h0);
        chk({tag, "_err"}, 32'(bus.err), 32'h0);
        chk({tag, "_dat"}, bus.dat_r, 32'h0);
        chk({tag, "_enable"}, 32'(enable), 32'h0);
        chk({tag, "_append"}, 32'(append), 32'h0);
        chk({tag, "_ndar"}, 32'(ndar), 32'h0);
        chk({tag, "_dirty"}, 32'(ndar_dirty), 32'h0);
        chk({tag, "_intclr"}, 32'(wb_int_clear), 32'h0);
        chk({tag, "_irq"}, 32'(irq_o), 32'h0);
    endtask

    initial begin
        bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
        bus.sel = 4'h0; bus.adr = '0; bus.dat_w = '0;
        #2 rst_n = 1'b0;
        #18;
        chk_reset_state("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        wr(5'h08, 32'h1000_0040);
        chk("ndar_value", 32'(ndar), 32'h0200_0008);
        chk("ndar_dirty_set", 32'(ndar_dirty), 32'h1);
        pulse_dirty();
        chk("ndar_dirty_cleared", 32'(ndar_dirty), 32'h0);
        rd(5'h08, 32'h1000_0040);

        wr(5'h08, 32'h1000_0040, 4'hF, 1'b1);
        chk("ndar_dirty_write_wins", 32'(ndar_dirty), 32'h1);

        wr(5'h00, 32'h0000_0103);
        chk("ccr_enable", 32'(enable), 32'h1);
        chk("ccr_append", 32'(append), 32'h1);
        wb_int_i = 1'b1;
        #1 chk("irq_on", 32'(irq_o), 32'h1);
        wr(5'h00, 32'h0000_0101);
        chk("append_write0_noop", 32'(append), 32'h1);
        pulse_append();
        chk("append_cleared", 32'(append), 32'h0);
        rd(5'h00, 32'h0000_0101);

        wr(5'h00, 32'h0000_0105);
        chk("int_clear_pulse", 32'(wb_int_clear), 32'h1);
        @(posedge clk); #1;
        chk("int_clear_one_cycle", 32'(wb_int_clear), 32'h0);
        rd(5'h00, 32'h0000_0101);

        wr(5'h00, 32'h0000_0000, 4'b0010);
        chk("irq_masked", 32'(irq_o), 32'h0);
        chk("enable_sel_kept", 32'(enable), 32'h1);
        rd(5'h00, 32'h0000_0001);

        ctrl_state_i = 8'hA5; busy_i = 1'b1; csr_i = 8'h3C; dar_i = 32'hDEAD_BEE8;
        rd(5'h04, 32'h00A5_033C);
        rd(5'h0C, 32'hDEAD_BEE8);

        wr(5'h08, 32'hFFFF_FFFF, 4'b0010);
        rd(5'h08, 32'h1000_FF40);
        pulse_dirty();
        wr(5'h08, 32'hFFFF_FFFF, 4'b0000);
        chk("ndar_sel0_no_dirty", 32'(ndar_dirty), 32'h0);
        chk("ndar_sel0_no_change", {ndar, 3'b000}, 32'h1000_FF40);

        access(1'b0, 5'h18, 32'h0, 4'hF, 1'b1, 32'h0);
        access(1'b1, 5'h1C, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0);
        chk("unmapped_no_effect", {ndar, 3'b000}, 32'h1000_FF40);

`ifdef SSDMA_REGS_STATS_EN
        wr(5'h10, 32'h0);
        repeat (3) pulse_append();
        rd(5'h10, 32'd3);
        wr(5'h10, 32'h0);
        rd(5'h10, 32'd0);
        wr(5'h14, 32'h0);
        repeat (2) begin
            @(posedge clk); #1 wb_int_i = 1'b0;
            @(posedge clk); #1 wb_int_i = 1'b1;
        end
        rd(5'h14, 32'd2);
`else
        access(1'b0, 5'h10, 32'h0, 4'hF, 1'b1, 32'h0);
        access(1'b0, 5'h14, 32'h0, 4'hF, 1'b1, 32'h0);
`endif

        wr(5'h00, 32'h0000_0103);
        chk("pre_reset_enable", 32'(enable), 32'h1);
        @(posedge clk); #1;
        bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b1;
        bus.adr = 5'h08; bus.dat_w = 32'h2000_0000; bus.sel = 4'hF;
        #2 rst_n = 1'b0;
        @(posedge clk); #1;
        chk_reset_state("midwrite");
        @(posedge clk); #1;
        bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
        @(negedge clk) rst_n = 1'b1;

        wr(5'h08, 32'h0000_0088);
        chk("post_reset_ndar", 32'(ndar), 32'h0000_0011);
        chk("post_reset_dirty", 32'(ndar_dirty), 32'h1);
        rd(5'h08, 32'h0000_0088);

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
